// File: rtl/ex_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_branch_unit
//  Brief    : Execute-stage ALU, NZCV flag register with same-cycle bypass,
//             condition tester and branch target/decision logic.
//  Revision : 1.0  initial release
// ============================================================================
module ex_branch_unit (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic        shift_carry,
    input  logic [3:0]  alu_op,
    input  logic        s_enable,
    input  logic [3:0]  cond,
    input  logic        b_instr,
    input  logic        bl_instr,
    input  logic [31:0] pc4,
    input  logic [23:0] offset,
    output logic [31:0] alu_result,
    output logic [3:0]  alu_flags,
    output logic [3:0]  flags_q,
    output logic        cond_true,
    output logic [31:0] target_addr,
    output logic        take_branch,
    output logic        bl_link
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_EOR = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_RSB = 4'b0011;
    localparam logic [3:0] c_OP_ADD = 4'b0100;
    localparam logic [3:0] c_OP_ADC = 4'b0101;
    localparam logic [3:0] c_OP_SBC = 4'b0110;
    localparam logic [3:0] c_OP_RSC = 4'b0111;
    localparam logic [3:0] c_OP_TST = 4'b1000;
    localparam logic [3:0] c_OP_TEQ = 4'b1001;
    localparam logic [3:0] c_OP_CMP = 4'b1010;
    localparam logic [3:0] c_OP_CMN = 4'b1011;
    localparam logic [3:0] c_OP_ORR = 4'b1100;
    localparam logic [3:0] c_OP_MOV = 4'b1101;
    localparam logic [3:0] c_OP_BIC = 4'b1110;
    localparam logic [3:0] c_OP_MVN = 4'b1111;

    logic [3:0]  r_flags;
    logic [31:0] w_add_x;
    logic [31:0] w_add_y;
    logic        w_add_cin;
    logic        w_is_arith;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_eff;
    logic        w_cond_pass;
    logic        w_cin_q;

    assign w_cin_q = r_flags[1];

    // Every arithmetic op is folded onto one adder: x + y + cin, with
    // subtraction expressed as x + ~y + 1 (or + C for the carry variants).
    always_comb begin
        w_add_x    = alu_a;
        w_add_y    = alu_b;
        w_add_cin  = 1'b0;
        w_is_arith = 1'b1;
        case (alu_op)
            c_OP_SUB, c_OP_CMP: begin w_add_y = ~alu_b; w_add_cin = 1'b1; end
            c_OP_RSB: begin w_add_x = alu_b; w_add_y = ~alu_a; w_add_cin = 1'b1; end
            c_OP_ADD, c_OP_CMN: w_add_cin = 1'b0;
            c_OP_ADC: w_add_cin = w_cin_q;
            c_OP_SBC: begin w_add_y = ~alu_b; w_add_cin = w_cin_q; end
            c_OP_RSC: begin w_add_x = alu_b; w_add_y = ~alu_a; w_add_cin = w_cin_q; end
            default:  w_is_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {32'd0, w_add_cin};

    always_comb begin
        w_result = w_sum[31:0];
        case (alu_op)
            c_OP_AND, c_OP_TST: w_result = alu_a & alu_b;
            c_OP_EOR, c_OP_TEQ: w_result = alu_a ^ alu_b;
            c_OP_ORR:           w_result = alu_a | alu_b;
            c_OP_MOV:           w_result = alu_b;
            c_OP_BIC:           w_result = alu_a & ~alu_b;
            c_OP_MVN:           w_result = ~alu_b;
            default:            w_result = w_sum[31:0];
        endcase
    end

    assign w_n = w_result[31];
    assign w_z = (w_result == 32'd0);
    // Logical ops take C from the shifter and leave V untouched.
    assign w_c = w_is_arith ? w_sum[32] : shift_carry;
    assign w_v = w_is_arith ? ((w_add_x[31] == w_add_y[31]) && (w_sum[31] != w_add_x[31]))
                            : r_flags[0];

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_flags <= 4'b0000;
        end else if (s_enable) begin
            r_flags <= {w_n, w_z, w_c, w_v};
        end
    end

    // Bypass lets a flag-setting op and its conditional consumer share a cycle.
    assign w_eff = s_enable ? {w_n, w_z, w_c, w_v} : r_flags;

    always_comb begin
        w_cond_pass = 1'b0;
        case (cond)
            4'b0000: w_cond_pass = w_eff[2];
            4'b0001: w_cond_pass = !w_eff[2];
            4'b0010: w_cond_pass = w_eff[1];
            4'b0011: w_cond_pass = !w_eff[1];
            4'b0100: w_cond_pass = w_eff[3];
            4'b0101: w_cond_pass = !w_eff[3];
            4'b0110: w_cond_pass = w_eff[0];
            4'b0111: w_cond_pass = !w_eff[0];
            4'b1000: w_cond_pass = w_eff[1] && !w_eff[2];
            4'b1001: w_cond_pass = !w_eff[1] || w_eff[2];
            4'b1010: w_cond_pass = (w_eff[3] == w_eff[0]);
            4'b1011: w_cond_pass = (w_eff[3] != w_eff[0]);
            4'b1100: w_cond_pass = !w_eff[2] && (w_eff[3] == w_eff[0]);
            4'b1101: w_cond_pass = w_eff[2] || (w_eff[3] != w_eff[0]);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign alu_result  = w_result;
    assign alu_flags   = {w_n, w_z, w_c, w_v};
    assign flags_q     = r_flags;
    assign cond_true   = w_cond_pass;
    assign target_addr = pc4 + {{6{offset[23]}}, offset, 2'b00};
    assign take_branch = (b_instr | bl_instr) & w_cond_pass;
    assign bl_link     = bl_instr & w_cond_pass;

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_branch_unit
//  Brief    : Table-driven directed bench for ex_branch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_branch_unit;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic        shift_carry = 1'b0;
    logic [3:0]  alu_op = '0;
    logic        s_enable = 1'b0;
    logic [3:0]  cond = '0;
    logic        b_instr = 1'b0;
    logic        bl_instr = 1'b0;
    logic [31:0] pc4 = '0;
    logic [23:0] offset = '0;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags_q;
    logic        cond_true;
    logic [31:0] target_addr;
    logic        take_branch;
    logic        bl_link;

    ex_branch_unit dut (
        .CLK(CLK), .CLR(CLR), .alu_a(alu_a), .alu_b(alu_b),
        .shift_carry(shift_carry), .alu_op(alu_op), .s_enable(s_enable),
        .cond(cond), .b_instr(b_instr), .bl_instr(bl_instr), .pc4(pc4),
        .offset(offset), .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .cond_true(cond_true), .target_addr(target_addr),
        .take_branch(take_branch), .bl_link(bl_link)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  pre;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        shc;
        logic        s;
        logic [3:0]  cnd;
        logic        bi;
        logic        bl;
        logic [31:0] pc;
        logic [23:0] off;
        logic [31:0] e_res;
        logic [3:0]  e_flg;
        logic        e_ct;
        logic [31:0] e_tgt;
        logic        e_take;
        logic        e_link;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reach any NZCV except N=Z=1: ADD sets V, then MOV sets N/Z/C keeping V.
    task automatic set_flags(input logic [3:0] f);
        b_instr  = 1'b0;
        bl_instr = 1'b0;
        alu_op   = 4'b0100;
        alu_a    = f[0] ? 32'h7FFF_FFFF : 32'd0;
        alu_b    = f[0] ? 32'd1 : 32'd0;
        s_enable = 1'b1;
        tick();
        alu_op      = 4'b1101;
        alu_b       = f[3] ? 32'h8000_0000 : (f[2] ? 32'd0 : 32'd1);
        shift_carry = f[1];
        tick();
        s_enable = 1'b0;
    endtask

    initial begin
        //          pre    op     a             b             shc  s    cond   bi   bl   pc4           off         res           flg    ct   tgt           tk   lk
        vecs[0]  = '{4'h0, 4'h4, 32'h7FFFFFFF, 32'h00000001, 1'b0,1'b1,4'h0, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h80000000, 4'h9, 1'b0,32'h00000000, 1'b0,1'b0};
        vecs[1]  = '{4'h0, 4'hA, 32'h00000005, 32'h00000005, 1'b0,1'b1,4'h0, 1'b1,1'b0,32'h00000100, 24'hFFFFFE, 32'h00000000, 4'h6, 1'b1,32'h000000F8, 1'b1,1'b0};
        vecs[2]  = '{4'h0, 4'h2, 32'h00000000, 32'h00000001, 1'b0,1'b1,4'h4, 1'b0,1'b0,32'h00000000, 24'h000000, 32'hFFFFFFFF, 4'h8, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[3]  = '{4'h0, 4'h5, 32'h00000001, 32'h00000001, 1'b0,1'b0,4'h2, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h00000002, 4'h0, 1'b0,32'h00000000, 1'b0,1'b0};
        vecs[4]  = '{4'h2, 4'h5, 32'h00000001, 32'h00000001, 1'b0,1'b0,4'h2, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h00000003, 4'h0, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[5]  = '{4'h1, 4'hD, 32'h00000000, 32'h00000000, 1'b1,1'b1,4'hF, 1'b1,1'b0,32'h00000000, 24'h000000, 32'h00000000, 4'h7, 1'b0,32'h00000000, 1'b0,1'b0};
        vecs[6]  = '{4'h0, 4'h0, 32'h00000000, 32'h00000000, 1'b0,1'b0,4'hE, 1'b0,1'b1,32'h00000020, 24'h000004, 32'h00000000, 4'h4, 1'b1,32'h00000030, 1'b1,1'b1};
        vecs[7]  = '{4'h4, 4'h0, 32'h00000000, 32'h00000000, 1'b0,1'b0,4'h1, 1'b0,1'b1,32'h00000020, 24'h000004, 32'h00000000, 4'h4, 1'b0,32'h00000030, 1'b0,1'b0};
        vecs[8]  = '{4'h0, 4'h6, 32'h0000000A, 32'h00000003, 1'b0,1'b1,4'hA, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h00000006, 4'h2, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[9]  = '{4'h0, 4'h3, 32'h00000001, 32'h80000000, 1'b0,1'b1,4'hB, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h7FFFFFFF, 4'h3, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[10] = '{4'h0, 4'h7, 32'h00000000, 32'h00000000, 1'b0,1'b0,4'h9, 1'b0,1'b0,32'h00000000, 24'h000000, 32'hFFFFFFFF, 4'h8, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[11] = '{4'h9, 4'h1, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0,1'b1,4'hC, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h0F0F0F0F, 4'h1, 1'b0,32'h00000000, 1'b0,1'b0};
        vecs[12] = '{4'h0, 4'hE, 32'h0000FFFF, 32'h000000FF, 1'b1,1'b1,4'h8, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h0000FF00, 4'h2, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[13] = '{4'h0, 4'hF, 32'h00000000, 32'h00000000, 1'b0,1'b1,4'hD, 1'b0,1'b0,32'h00000000, 24'h000000, 32'hFFFFFFFF, 4'h8, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[14] = '{4'h0, 4'hB, 32'hFFFFFFFF, 32'h00000001, 1'b0,1'b1,4'h3, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h00000000, 4'h6, 1'b0,32'h00000000, 1'b0,1'b0};
        vecs[15] = '{4'h0, 4'hC, 32'h00000012, 32'h00000021, 1'b0,1'b0,4'h5, 1'b1,1'b0,32'h00001000, 24'h800000, 32'h00000033, 4'h0, 1'b1,32'hFE001000, 1'b1,1'b0};
        vecs[16] = '{4'h0, 4'h8, 32'h000000F0, 32'h0000000F, 1'b1,1'b1,4'h0, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h00000000, 4'h6, 1'b1,32'h00000000, 1'b0,1'b0};
        vecs[17] = '{4'h1, 4'h9, 32'h00000005, 32'h00000005, 1'b0,1'b0,4'h7, 1'b0,1'b0,32'h00000000, 24'h000000, 32'h00000000, 4'h5, 1'b0,32'h00000000, 1'b0,1'b0};
        vecs[18] = '{4'h0, 4'hD, 32'h00000000, 32'h00000001, 1'b0,1'b0,4'hE, 1'b1,1'b0,32'hFFFFFFF0, 24'h7FFFFF, 32'h00000001, 4'h0, 1'b1,32'h01FFFFEC, 1'b1,1'b0};

        // Reset state and hold while CLR is low.
        #2;
        chk("reset_flags_q", {28'd0, flags_q}, 32'd0);
        alu_op = 4'b0100; alu_a = 32'h7FFF_FFFF; alu_b = 32'd1; s_enable = 1'b1;
        tick();
        chk("reset_hold_flags_q", {28'd0, flags_q}, 32'd0);
        CLR = 1'b1;
        chk("reset_release_no_load", {28'd0, flags_q}, 32'd0);
        tick();
        chk("first_load_flags_q", {28'd0, flags_q}, 32'h9);
        s_enable = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_flags(vecs[i].pre);
            chk($sformatf("v%0d_preset", i), {28'd0, flags_q}, {28'd0, vecs[i].pre});
            alu_op = vecs[i].op; alu_a = vecs[i].a; alu_b = vecs[i].b;
            shift_carry = vecs[i].shc; s_enable = vecs[i].s; cond = vecs[i].cnd;
            b_instr = vecs[i].bi; bl_instr = vecs[i].bl; pc4 = vecs[i].pc; offset = vecs[i].off;
            #1;
            chk($sformatf("v%0d_result", i), alu_result, vecs[i].e_res);
            chk($sformatf("v%0d_flags", i), {28'd0, alu_flags}, {28'd0, vecs[i].e_flg});
            chk($sformatf("v%0d_cond_true", i), {31'd0, cond_true}, {31'd0, vecs[i].e_ct});
            chk($sformatf("v%0d_target", i), target_addr, vecs[i].e_tgt);
            chk($sformatf("v%0d_take", i), {31'd0, take_branch}, {31'd0, vecs[i].e_take});
            chk($sformatf("v%0d_link", i), {31'd0, bl_link}, {31'd0, vecs[i].e_link});
            tick();
            chk($sformatf("v%0d_flags_q", i), {28'd0, flags_q},
                {28'd0, (vecs[i].s ? vecs[i].e_flg : vecs[i].pre)});
            s_enable = 1'b0; b_instr = 1'b0; bl_instr = 1'b0; cond = 4'h0;
        end

        // Back-to-back ADC consumes the carry registered at the previous edge.
        alu_op = 4'b1010; alu_a = 32'd5; alu_b = 32'd5; s_enable = 1'b1;
        tick();
        alu_op = 4'b0101; alu_a = 32'd1; alu_b = 32'd1; s_enable = 1'b1;
        #1;
        chk("adc_after_cmp", alu_result, 32'd3);
        tick();
        chk("adc_flags_q", {28'd0, flags_q}, 32'h0);
        #1;
        chk("adc_after_adc", alu_result, 32'd2);
        s_enable = 1'b0;

        // Asynchronous clear in the middle of a cycle.
        set_flags(4'b0100);
        chk("async_preset", {28'd0, flags_q}, 32'h4);
        #2;
        CLR = 1'b0;
        #1;
        chk("async_clear_flags_q", {28'd0, flags_q}, 32'h0);
        cond = 4'b0000; #1;
        chk("async_clear_eq", {31'd0, cond_true}, 32'd0);
        cond = 4'b0001; #1;
        chk("async_clear_ne", {31'd0, cond_true}, 32'd1);
        cond = 4'b1110; #1;
        chk("async_clear_al", {31'd0, cond_true}, 32'd1);
        CLR = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
